// File: rtl/multdiv_issue_ctrl_if.sv
// Decode/multdiv/writeback signal bundle for the mul/div issue controller.
// Combinational bundle, no latency of its own.
// The controller is the slave; stall is the only backpressure, carried as a plain level.
interface multdiv_issue_ctrl_if;
    logic        instr_valid;
    logic [4:0]  opcode;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic        flush;
    logic        data_resultRDY;
    logic        data_exception;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        busy;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        wb_status_sel;
    logic [31:0] wb_status;

    // Decoder / multdiv / regfile side
    modport master (
        output instr_valid, opcode, aluop, rd, flush, data_resultRDY, data_exception,
        input  ctrl_MULT, ctrl_DIV, stall, busy, wb_en, wb_rd, wb_status_sel, wb_status
    );

    // Issue controller side
    modport slave (
        input  instr_valid, opcode, aluop, rd, flush, data_resultRDY, data_exception,
        output ctrl_MULT, ctrl_DIV, stall, busy, wb_en, wb_rd, wb_status_sel, wb_status
    );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issues R-type mul/div to the multi-cycle unit, stalls decode until the result, then one writeback.
// Latency: hit -> WB in 3 cycles minimum (ready on the first WAIT cycle); outputs registered except stall.
// Backpressure: stall holds PC/decode through IDLE-hit, ISSUE and WAIT; optional watchdog via MULTDIV_TIMEOUT_EN.
module multdiv_issue_ctrl #(
`ifdef MULTDIV_TIMEOUT_EN
    parameter int unsigned CNT_W          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 40,
`endif
    parameter int unsigned STATUS_MUL     = 4,
    parameter int unsigned STATUS_DIV     = 5,
    parameter int unsigned STATUS_TMO     = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_issue_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [4:0] RSTATUS_REG = 5'd30;

    state_t      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_div_q, is_div_d;
    logic        mult_q, mult_d;
    logic        div_q, div_d;
    logic        busy_q, busy_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_sel_q, wb_sel_d;
    logic [31:0] wb_status_q, wb_status_d;
`ifdef MULTDIV_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic hit;

    // ALU ops 00110 (mul) and 00111 (div) differ only in bit 0
    assign hit = bus.instr_valid && (bus.opcode == 5'b00000) && (bus.aluop[4:1] == 4'b0011);

    // Next state and next registered outputs; outputs describe the state being entered
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        is_div_d    = is_div_q;
        mult_d      = 1'b0;
        div_d       = 1'b0;
        busy_d      = 1'b0;
        wb_en_d     = 1'b0;
        wb_rd_d     = 5'd0;
        wb_sel_d    = 1'b0;
        wb_status_d = 32'd0;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // flush is meaningless here; nothing is in flight
                if (hit) begin
                    state_d  = S_ISSUE;
                    rd_d     = bus.rd;
                    is_div_d = bus.aluop[0];
                    mult_d   = ~bus.aluop[0];
                    div_d    = bus.aluop[0];
                    busy_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                // any ready seen here belongs to an older operation
`ifdef MULTDIV_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
`ifdef MULTDIV_TIMEOUT_EN
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (bus.flush) begin
                    // squash beats a same-cycle result: no writeback
                    state_d = S_IDLE;
                end else if (bus.data_resultRDY) begin
                    state_d = S_WB;
                    busy_d  = 1'b1;
                    if (bus.data_exception) begin
                        wb_en_d     = 1'b1;
                        wb_rd_d     = RSTATUS_REG;
                        wb_sel_d    = 1'b1;
                        wb_status_d = is_div_q ? 32'(STATUS_DIV) : 32'(STATUS_MUL);
                    end else if (rd_q != 5'd0) begin
                        wb_en_d = 1'b1;
                        wb_rd_d = rd_q;
                    end
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_WB;
                    busy_d      = 1'b1;
                    wb_en_d     = 1'b1;
                    wb_rd_d     = RSTATUS_REG;
                    wb_sel_d    = 1'b1;
                    wb_status_d = 32'(STATUS_TMO);
                end
`endif
                else begin
                    busy_d = 1'b1;
                end
            end
            S_WB: begin
                // a hit re-presented here is taken once back in IDLE
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched operation and registered outputs; reset clears everything mid-operation
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rd_q        <= 5'd0;
            is_div_q    <= 1'b0;
            mult_q      <= 1'b0;
            div_q       <= 1'b0;
            busy_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_sel_q    <= 1'b0;
            wb_status_q <= 32'd0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            is_div_q    <= is_div_d;
            mult_q      <= mult_d;
            div_q       <= div_d;
            busy_q      <= busy_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_sel_q    <= wb_sel_d;
            wb_status_q <= wb_status_d;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // stall is combinational so decode freezes in the same cycle the hit appears
    assign bus.stall = ((state_q == S_IDLE) && hit) || (state_q == S_ISSUE) || (state_q == S_WAIT);

    assign bus.ctrl_MULT     = mult_q;
    assign bus.ctrl_DIV      = div_q;
    assign bus.busy          = busy_q;
    assign bus.wb_en         = wb_en_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_status_sel = wb_sel_q;
    assign bus.wb_status     = wb_status_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;

    typedef struct packed {
        logic        stall;
        logic        busy;
        logic        mult;
        logic        div;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic        sel;
        logic [31:0] status;
    } out_t;

    localparam int MAXT = 128;
`ifdef MULTDIV_TIMEOUT_EN
    localparam int TMO_CYC = 40;
`endif

    logic clock;
    logic reset;
    multdiv_issue_ctrl_if bus();

    multdiv_issue_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Transaction description: t=0 is the IDLE cycle presenting the hit, ISSUE is t=1,
    // ready arrives at t = t_d + 1, flush at t = t_f (negative: none)
    bit       t_div;
    bit [4:0] t_rd;
    int       t_d;
    bit       t_exc;
    int       t_f;
    bit       t_stale;
    bit       t_holdwb;

    out_t exp_tr [MAXT];
    out_t obs_tr [MAXT];
    int   tr_len;
    int   m_last;
    int   m_w;
    bit   m_ab;

    function automatic out_t sample();
        out_t o;
        o.stall  = bus.stall;
        o.busy   = bus.busy;
        o.mult   = bus.ctrl_MULT;
        o.div    = bus.ctrl_DIV;
        o.wb_en  = bus.wb_en;
        o.wb_rd  = bus.wb_rd;
        o.sel    = bus.wb_status_sel;
        o.status = bus.wb_status;
        return o;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("stall=%b busy=%b mul=%b div=%b wb_en=%b wb_rd=%0d sel=%b status=%0d",
                         o.stall, o.busy, o.mult, o.div, o.wb_en, o.wb_rd, o.sel, o.status);
    endfunction

    // Expected cycle-by-cycle outputs from the operation's timeline
    task automatic model_txn();
        bit tmo;
        out_t e;
        tmo = 1'b0;
        m_w = t_d + 2;
`ifdef MULTDIV_TIMEOUT_EN
        if (t_d > TMO_CYC) begin
            tmo = 1'b1;
            m_w = TMO_CYC + 2;
        end
`endif
        m_ab   = (t_f >= 1) && (t_f <= m_w - 1);
        m_last = m_ab ? t_f : m_w - 1;
        tr_len = (m_ab ? t_f : m_w) + 2;
        if (tr_len > MAXT) tr_len = MAXT;
        for (int t = 0; t < tr_len; t++) begin
            e        = '0;
            e.stall  = (t <= m_last);
            e.busy   = (t >= 1) && (t <= (m_ab ? t_f : m_w));
            e.mult   = (t == 1) && !t_div;
            e.div    = (t == 1) && t_div;
            if (!m_ab && t == m_w) begin
                if (tmo) begin
                    e.wb_en = 1'b1; e.wb_rd = 5'd30; e.sel = 1'b1; e.status = 32'd7;
                end else if (t_exc) begin
                    e.wb_en = 1'b1; e.wb_rd = 5'd30; e.sel = 1'b1;
                    e.status = t_div ? 32'd5 : 32'd4;
                end else if (t_rd != 5'd0) begin
                    e.wb_en = 1'b1; e.wb_rd = t_rd;
                end
            end
            exp_tr[t] = e;
        end
    endtask

    task automatic drive_nonhit();
        bus.instr_valid = 1'($urandom);
        bus.rd          = 5'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            bus.opcode = 5'($urandom_range(1, 31));
            bus.aluop  = 5'($urandom);
        end else begin
            bus.opcode = 5'd0;
            bus.aluop  = 5'($urandom_range(0, 29));
            if (bus.aluop >= 5'd6) bus.aluop = bus.aluop + 5'd2;
        end
    endtask

    // Drives one transaction and records what the DUT shows each cycle
    task automatic run_txn();
        for (int t = 0; t < tr_len; t++) begin
            @(posedge clock); #1;
            if (t <= m_last || (t_holdwb && !m_ab && t == m_w)) begin
                bus.instr_valid = 1'b1;
                bus.opcode      = 5'd0;
                bus.aluop       = t_div ? 5'b00111 : 5'b00110;
                bus.rd          = t_rd;
            end else begin
                drive_nonhit();
            end
            bus.flush          = (t == t_f);
            bus.data_resultRDY = (t == t_d + 1) || (t_stale && t == 1);
            bus.data_exception = (t == t_d + 1) ? t_exc : 1'($urandom);
            @(negedge clock);
            obs_tr[t] = sample();
        end
    endtask

    task automatic set_txn(input bit dv, input bit [4:0] r, input int d, input bit ex, input int f);
        t_div = dv; t_rd = r; t_d = d; t_exc = ex; t_f = f; t_stale = 1'b0; t_holdwb = 1'b0;
        model_txn();
        run_txn();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.instr_valid = 1'b0; bus.opcode = 5'd0; bus.aluop = 5'd0; bus.rd = 5'd0;
        bus.flush = 1'b0; bus.data_resultRDY = 1'b0; bus.data_exception = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (sample() !== out_t'(0)) begin
                failures++;
                $display("FAIL reset cyc=%0d got %s expected all zero", i, fmt(sample()));
            end
        end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_mul_basic();
        set_txn(1'b0, 5'd5, 10, 1'b0, -1);
        for (int t = 0; t < tr_len; t++) begin
            checks++;
            if (obs_tr[t] !== exp_tr[t]) begin
                failures++;
                $display("FAIL mul_basic t=%0d got %s expected %s", t, fmt(obs_tr[t]), fmt(exp_tr[t]));
            end
        end
    endtask

    task automatic test_exception();
        for (int k = 0; k < 2; k++) begin
            set_txn(k == 0, 5'd3, 1 + k * 3, 1'b1, -1);
            for (int t = 0; t < tr_len; t++) begin
                checks++;
                if (obs_tr[t] !== exp_tr[t]) begin
                    failures++;
                    $display("FAIL exception k=%0d t=%0d got %s expected %s", k, t, fmt(obs_tr[t]), fmt(exp_tr[t]));
                end
            end
        end
    endtask

    task automatic test_rd_zero();
        set_txn(1'b0, 5'd0, 2, 1'b0, -1);
        for (int t = 0; t < tr_len; t++) begin
            checks++;
            if (obs_tr[t] !== exp_tr[t]) begin
                failures++;
                $display("FAIL rd_zero t=%0d got %s expected %s", t, fmt(obs_tr[t]), fmt(exp_tr[t]));
            end
        end
    endtask

    // Flush on the ready cycle, flush in ISSUE, then a clean op right after
    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       set_txn(1'b0, 5'd9, 4, 1'b0, 5);
                1:       set_txn(1'b1, 5'd7, 3, 1'b1, 1);
                default: set_txn(1'b1, 5'd12, 1, 1'b0, -1);
            endcase
            for (int t = 0; t < tr_len; t++) begin
                checks++;
                if (obs_tr[t] !== exp_tr[t]) begin
                    failures++;
                    $display("FAIL flush k=%0d t=%0d got %s expected %s", k, t, fmt(obs_tr[t]), fmt(exp_tr[t]));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t o;
        for (int t = 0; t < 6; t++) begin
            @(posedge clock); #1;
            bus.instr_valid = 1'b1; bus.opcode = 5'd0; bus.aluop = 5'b00111; bus.rd = 5'd8;
            bus.flush = 1'b0; bus.data_resultRDY = 1'b0; bus.data_exception = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b1 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got busy=%b stall=%b expected 1 1", bus.busy, bus.stall);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        bus.instr_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        o = sample();
        checks++;
        if (o !== out_t'(0)) begin
            failures++;
            $display("FAIL reset_mid_clear got %s expected all zero", fmt(o));
        end
        @(posedge clock); #1;
        bus.data_resultRDY = 1'b1; bus.data_exception = 1'b1;
        @(posedge clock); #1;
        bus.data_resultRDY = 1'b0; bus.data_exception = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            o = sample();
            checks++;
            if (o !== out_t'(0)) begin
                failures++;
                $display("FAIL reset_mid_late_ready cyc=%0d got %s expected all zero", i, fmt(o));
            end
            @(posedge clock); #1;
        end
    endtask

    // Ready withheld; flush at t=105 only matters when no watchdog is built in
    task automatic test_timeout();
        set_txn(1'b0, 5'd6, 200, 1'b0, 105);
        for (int t = 0; t < tr_len; t++) begin
            checks++;
            if (obs_tr[t] !== exp_tr[t]) begin
                failures++;
                $display("FAIL timeout t=%0d got %s expected %s", t, fmt(obs_tr[t]), fmt(exp_tr[t]));
            end
        end
    endtask

    task automatic test_random_back_to_back();
        for (int n = 0; n < 40; n++) begin
            t_div    = 1'($urandom);
            t_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            t_d      = ($urandom_range(0, 6) == 0) ? $urandom_range(38, 50) : $urandom_range(1, 12);
            t_exc    = ($urandom_range(0, 2) == 0);
            t_f      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, t_d + 2) : -1;
            t_stale  = 1'($urandom);
            t_holdwb = 1'($urandom);
            model_txn();
            run_txn();
            for (int t = 0; t < tr_len; t++) begin
                checks++;
                if (obs_tr[t] !== exp_tr[t]) begin
                    failures++;
                    $display("FAIL random n=%0d t=%0d d=%0d f=%0d got %s expected %s",
                             n, t, t_d, t_f, fmt(obs_tr[t]), fmt(exp_tr[t]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_exception();
        test_rd_zero();
        test_flush();
        test_reset_mid();
        test_timeout();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
